// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    // Writes to register 0 are discarded, so it can never create a dependency.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and the control outputs that steer them.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] Rs1;
    logic [REG_W-1:0] Rt1;
    logic             UseRt1;
    logic             MemRead2;
    logic [REG_W-1:0] Wreg_addr2;
    logic             MemRead4;
    logic             MemWrite4;
    logic             Branch4;
    logic             PCSrc4;
    logic             JtoPC4;
    logic             dmem_ready;

    logic             dmem_req;
    logic             PC_en;
    logic             IFID_en;
    logic             IDEX_en;
    logic             EXMEM_en;
    logic             MEMWB_en;
    logic             IFID_flush;
    logic             IDEX_flush;
    logic             EXMEM_flush;
    logic             MEMWB_bubble;
    logic             redirect;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output Rs1, Rt1, UseRt1, MemRead2, Wreg_addr2, MemRead4, MemWrite4,
               Branch4, PCSrc4, JtoPC4, dmem_ready,
        input  dmem_req, PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
               IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_bubble, redirect,
               mem_err, stall_cycles
    );

    modport slave (
        input  Rs1, Rt1, UseRt1, MemRead2, Wreg_addr2, MemRead4, MemWrite4,
               Branch4, PCSrc4, JtoPC4, dmem_ready,
        output dmem_req, PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
               IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_bubble, redirect,
               mem_err, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait sequencer: tracks outstanding access, counts wait cycles,
// and latches a sticky error when the memory never answers.
module mem_wait_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic   clk,
    input  logic   srst,
    input  logic   mem_op_i,
    input  logic   dmem_ready_i,
    output state_e state_o,
    output logic   mem_err_o
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_op_i && !dmem_ready_i) begin
                    // The first frozen cycle already counts as one wait cycle.
                    wait_cnt_d = WAIT_W'(1);
                    state_d    = (wait_cnt_d >= TIMEOUT_W) ? ST_ERR : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready_i) begin
                    wait_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_d >= TIMEOUT_W) begin
                        state_d = ST_ERR;
                    end
                end
            end
            default: state_d = ST_ERR;
        endcase
        mem_err_d = mem_err_q | (state_d == ST_ERR);
    end

    assign state_o   = state_q;
    assign mem_err_o = mem_err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory freeze has priority
// over branch/jump redirect, which has priority over the load-use bubble.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    pipe_hazard_ctrl_if.slave bus
);
    state_e           state;
    logic             mem_err;
    logic             mem_op, take, lu, busy, frozen;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, memwb_bubble;
    logic             dmem_req, redirect;
    logic [CNT_W-1:0] stall_q, stall_d;

    mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait_fsm (
        .clk          (CLK),
        .srst         (RST),
        .mem_op_i     (mem_op),
        .dmem_ready_i (bus.dmem_ready),
        .state_o      (state),
        .mem_err_o    (mem_err)
    );

    assign mem_op = bus.MemRead4 | bus.MemWrite4;
    assign take   = (bus.Branch4 & bus.PCSrc4) | bus.JtoPC4;
    assign lu     = bus.MemRead2 & (bus.Wreg_addr2 != REG_W'(REG_ZERO))
                  & ((bus.Wreg_addr2 == bus.Rs1)
                     | (bus.UseRt1 & (bus.Wreg_addr2 == bus.Rt1)));
    assign busy   = (state == ST_MEM_WAIT) | ((state == ST_RUN) & mem_op);
    assign frozen = busy & ~bus.dmem_ready;

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        dmem_req     = 1'b0;
        redirect     = 1'b0;
        if (RST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            {ifid_flush, idex_flush, exmem_flush, memwb_bubble} = '1;
        end else if (state == ST_ERR) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else begin
            dmem_req = busy;
            if (frozen) begin
                // Hold everything upstream of MEM; WB keeps draining bubbles.
                {pc_en, ifid_en, idex_en, exmem_en} = '0;
                memwb_bubble = 1'b1;
            end else if (take) begin
                redirect    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (lu) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.dmem_req     = dmem_req;
    assign bus.PC_en        = pc_en;
    assign bus.IFID_en      = ifid_en;
    assign bus.IDEX_en      = idex_en;
    assign bus.EXMEM_en     = exmem_en;
    assign bus.MEMWB_en     = memwb_en;
    assign bus.IFID_flush   = ifid_flush;
    assign bus.IDEX_flush   = idex_flush;
    assign bus.EXMEM_flush  = exmem_flush;
    assign bus.MEMWB_bubble = memwb_bubble;
    assign bus.redirect     = redirect;
    assign bus.mem_err      = mem_err;
    assign bus.stall_cycles = stall_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It drives the load enables and flush/bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use hazards.
- Redirects on taken branch/jump resolved in MEM.
- Sequences a variable-latency data-memory handshake, with a timeout error.

Parameters:
REG_W, 5, register-address width
MEM_TIMEOUT, 64, max wait cycles for dmem_ready before error
CNT_W, 16, width of the stall-cycle counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
Rs1  in  REG_W  rs of instruction in ID
Rt1  in  REG_W  rt of instruction in ID
UseRt1  in  1  ID instruction reads rt
MemRead2  in  1  EX-stage instruction is a load
Wreg_addr2  in  REG_W  EX-stage destination register
MemRead4  in  1  MEM-stage load
MemWrite4  in  1  MEM-stage store
Branch4  in  1  MEM-stage branch
PCSrc4  in  1  MEM-stage branch condition true
JtoPC4  in  1  MEM-stage jump
dmem_ready  in  1  data memory completes access this cycle
dmem_req  out  1  data-memory access request
PC_en  out  1  PC load enable
IFID_en, IDEX_en, EXMEM_en, MEMWB_en  out  1 each  pipeline-register load enables
IFID_flush, IDEX_flush, EXMEM_flush  out  1 each  load bubble (all controls 0)
MEMWB_bubble  out  1  MEM/WB loads bubble
redirect  out  1  PC selects branch/jump target
mem_err  out  1  sticky timeout error
stall_cycles  out  CNT_W  saturating count of freeze cycles

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Registered state: FSM state, wait counter, mem_err, stall_cycles. All other outputs are combinational from state and inputs; there is no extra latency.
- RST high at a rising edge: state=RUN, wait counter=0, mem_err=0, stall_cycles=0.
- While RST is high, outputs are forced to: all *_en=0, all *_flush=1, MEMWB_bubble=1, dmem_req=0, redirect=0.
- Signal definitions:
  - mem_op = MemRead4 | MemWrite4
  - take = (Branch4 & PCSrc4) | JtoPC4
  - lu = MemRead2 & (Wreg_addr2 != 0) & ((Wreg_addr2 == Rs1) | (UseRt1 & (Wreg_addr2 == Rt1)))
- FSM states: RUN, MEM_WAIT, ERR.
- RUN, default: all *_en=1, flushes=0.
  - mem_op: dmem_req=1.
    - dmem_ready=1: zero-wait completion, no stall.
    - Otherwise: freeze this cycle (PC_en=IFID_en=IDEX_en=EXMEM_en=0, MEMWB_en=1, MEMWB_bubble=1), wait counter=1, next state MEM_WAIT.
  - take (not frozen): redirect=1, IFID_flush=IDEX_flush=EXMEM_flush=1; all enables stay 1.
  - lu (no take, not frozen): PC_en=0, IFID_en=0, IDEX_flush=1; one bubble per hazard.
  - Priority: memory freeze > take > lu.
- MEM_WAIT: dmem_req=1; freeze pattern as above; wait counter increments.
  - dmem_ready=1: that cycle behaves exactly as RUN with zero-wait completion (take and lu evaluated normally); next state RUN, counter cleared.
  - Counter reaches MEM_TIMEOUT without ready: next state ERR.
- ERR: all *_en=0, dmem_req=0, mem_err=1. Held until RST.
- stall_cycles: +1 on every cycle in which PC_en=0 (load-use, MEM_WAIT or ERR, RST excluded). Saturates at all-ones; no wrap.
- Boundary rules:
  - Register 0 never causes a load-use stall.
  - mem_op and take together (malformed encoding): memory handled first; redirect asserted in the completion cycle.
  - RST mid-MEM_WAIT: returns to RUN; no dmem_req in the reset cycle.

Decomposition:
- Shared package: FSM state encoding (RUN/MEM_WAIT/ERR), REG_ZERO constant.
- One sub-module, mem_wait_fsm: holds state, wait counter, timeout and mem_err.
- Hazard/redirect priority logic stays in the top module.

Test Plan:
- Load-use: MemRead2=1, Wreg_addr2=8, Rs1=8 -> exactly one cycle of PC_en=0, IFID_en=0, IDEX_flush=1; stall_cycles=1. Same stimulus with Wreg_addr2=0 -> no stall.
- Taken branch: Branch4=1, PCSrc4=1 -> redirect=1, IFID/IDEX/EXMEM_flush=1 for one cycle, PC_en=1. PCSrc4=0 -> no flush.
- Load with dmem_ready after 3 cycles -> 3 freeze cycles, MEMWB_bubble=1 each, dmem_req high for 4 cycles, enables restored on the 4th; stall_cycles=3.
- Zero-wait store (dmem_ready=1 same cycle) -> no freeze, stall_cycles unchanged.
- dmem_ready never asserted, MEM_TIMEOUT=4 -> ERR entered after 4 wait cycles, mem_err=1, enables 0. Persists until RST; RST clears mem_err and state.
- RST asserted during MEM_WAIT plus simultaneous lu and take -> outputs forced to reset pattern. RUN next cycle with stall_cycles=0.
